// File: rtl/num_pattern_gen_pkg.sv
// Shared definitions for the 1-1-2-2-3-3 pattern generator.
// Covers the FSM state encoding, the symbol constants and the symbol-advance helper.
package num_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYM  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [1:0] SYM_IDLE = 2'b00;
  localparam logic [1:0] SYM_1    = 2'b01;
  localparam logic [1:0] SYM_2    = 2'b10;
  localparam logic [1:0] SYM_3    = 2'b11;

  function automatic logic [1:0] next_sym(input logic [1:0] sym);
    case (sym)
      SYM_1:   next_sym = SYM_2;
      SYM_2:   next_sym = SYM_3;
      default: next_sym = SYM_1;
    endcase
  endfunction

endpackage

// File: rtl/num_pattern_gen.sv
// Burst generator: emits REP copies each of symbols 1, 2 and 3 for each frame.
// Frames are separated by GAP idle cycles. Every output is registered.
module num_pattern_gen
  import num_pattern_gen_pkg::*;
#(
  parameter int REP = 2,
  parameter int GAP = 1,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] frames,
  output logic [1:0]    num,
  output logic          num_vld,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] frame_cnt,
  output state_e        dbg_state
);

  // One down-counter serves both symbol repeats and gap length.
  localparam int CNT_MAX = (REP > GAP) ? REP : GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REP - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  state_e           state_q, state_d;
  logic [1:0]       sym_q, sym_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    frames_q, frames_d;
  logic [CW-1:0]    frame_cnt_q, frame_cnt_d;
  logic [1:0]       num_q, num_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_frame;
  logic [CW-1:0]    frame_cnt_inc;

  assign last_frame    = (frame_cnt_q == frames_q - CW'(1));
  assign frame_cnt_inc = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    sym_d       = sym_q;
    cnt_d       = cnt_q;
    frames_d    = frames_q;
    frame_cnt_d = frame_cnt_q;
    num_d       = SYM_IDLE;
    vld_d       = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start && !abort && (frames != '0)) begin
          state_d     = ST_SYM;
          frames_d    = frames;
          frame_cnt_d = '0;
          sym_d       = SYM_1;
          cnt_d       = REP_LAST;
          num_d       = SYM_1;
          vld_d       = 1'b1;
          busy_d      = 1'b1;
        end
      end
      ST_SYM: begin
        busy_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          num_d = sym_q;
          vld_d = 1'b1;
        end else if (sym_q != SYM_3) begin
          sym_d = next_sym(sym_q);
          cnt_d = REP_LAST;
          num_d = next_sym(sym_q);
          vld_d = 1'b1;
        end else begin
          // Final copy of 3 has just been shown: the frame is complete.
          frame_cnt_d = frame_cnt_inc;
          sym_d       = SYM_1;
          if (last_frame) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else if (GAP > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LAST;
          end else begin
            cnt_d = REP_LAST;
            num_d = SYM_1;
            vld_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        busy_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_SYM;
          sym_d   = SYM_1;
          cnt_d   = REP_LAST;
          num_d   = SYM_1;
          vld_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A frame whose last symbol was already shown still counts as completed.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      sym_d   = SYM_1;
      cnt_d   = '0;
      num_d   = SYM_IDLE;
      vld_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sym_q       <= SYM_1;
      cnt_q       <= '0;
      frames_q    <= '0;
      frame_cnt_q <= '0;
      num_q       <= SYM_IDLE;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      cnt_q       <= cnt_d;
      frames_q    <= frames_d;
      frame_cnt_q <= frame_cnt_d;
      num_q       <= num_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign num       = num_q;
  assign num_vld   = vld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_cnt = frame_cnt_q;
  assign dbg_state = state_q;

endmodule
